// File: rtl/hog_axil_pkg.sv
//----------------------------------------------------------------------------
// Module   : hog_axil_pkg
// Brief    : Shared types and constants for the HOG GP AXI4-Lite master.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package hog_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

`default_nettype wire

// File: rtl/axil_gp_master_arb_rr_arb2.sv
//----------------------------------------------------------------------------
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter; pointer moves only on advance.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Requester favoured when both ask at once; starts at requester 0.
    logic r_prio;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio <= 1'b0;
        end else if (advance && (|grant)) begin
            r_prio <= grant[0];
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_prio ? 2'b10 : 2'b01;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axil_gp_master_arb.sv
//----------------------------------------------------------------------------
// Module   : axil_gp_master_arb
// Brief    : Two-requester AXI4-Lite master for the HOG GP register port.
//            Define AXIL_GP_STRB_EN to add per-requester write strobes.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module axil_gp_master_arb
    import hog_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_we,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
`ifdef AXIL_GP_STRB_EN
    input  logic [2*(DATA_WIDTH/8)-1:0] req_strb,
`endif
    output logic [1:0]                req_done,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic [1:0]                rsp_resp,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t                  r_state, w_state_nxt;
    logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                    w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt, w_arvalid_nxt, w_rready_nxt;
    logic [1:0]              r_done, w_done_nxt;
    logic [DATA_WIDTH-1:0]   r_rsp_data, w_rsp_data_nxt;
    logic [1:0]              r_rsp_resp, w_rsp_resp_nxt;
    logic [1:0]              r_gnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [1:0]              w_req, w_gnt;
    logic                    w_adv, w_sel_we, w_aw_done, w_w_done;

    // A requester whose done is pulsing is still holding valid; skip it.
    assign w_req    = req_valid & ~r_done;
    assign w_adv    = (r_state == ST_IDLE) && (|w_req);
    assign w_sel_we = w_gnt[1] ? req_we[1] : req_we[0];

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_adv),
        .grant   (w_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_done     <= 2'b00;
            r_rsp_data <= '0;
            r_rsp_resp <= OKAY;
        end else begin
            r_state    <= w_state_nxt;
            r_awvalid  <= w_awvalid_nxt;
            r_wvalid   <= w_wvalid_nxt;
            r_bready   <= w_bready_nxt;
            r_arvalid  <= w_arvalid_nxt;
            r_rready   <= w_rready_nxt;
            r_done     <= w_done_nxt;
            r_rsp_data <= w_rsp_data_nxt;
            r_rsp_resp <= w_rsp_resp_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_awvalid_nxt  = r_awvalid;
        w_wvalid_nxt   = r_wvalid;
        w_bready_nxt   = r_bready;
        w_arvalid_nxt  = r_arvalid;
        w_rready_nxt   = r_rready;
        w_done_nxt     = 2'b00;
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_resp_nxt = r_rsp_resp;
        w_aw_done      = !r_awvalid || m_axi_awready;
        w_w_done       = !r_wvalid  || m_axi_wready;
        case (r_state)
            ST_IDLE: begin
                if (w_adv) begin
                    if (w_sel_we) begin
                        w_state_nxt   = ST_WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            ST_WR: begin
                w_awvalid_nxt = r_awvalid && !m_axi_awready;
                w_wvalid_nxt  = r_wvalid  && !m_axi_wready;
                if (w_aw_done && w_w_done) begin
                    w_state_nxt  = ST_WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    w_rsp_resp_nxt = m_axi_bresp;
                    w_rsp_data_nxt = '0;
                    w_done_nxt     = r_gnt;
                    w_bready_nxt   = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (m_axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    w_rsp_resp_nxt = m_axi_rresp;
                    w_rsp_data_nxt = m_axi_rdata;
                    w_done_nxt     = r_gnt;
                    w_rready_nxt   = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command capture at grant; held stable for the whole transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt   <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_adv) begin
            r_gnt   <= w_gnt;
            r_addr  <= w_gnt[1] ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
            r_wdata <= w_gnt[1] ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        end
    end

`ifdef AXIL_GP_STRB_EN
    logic [STRB_W-1:0] r_strb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_strb <= '0;
        end else if (w_adv) begin
            r_strb <= w_gnt[1] ? req_strb[2*STRB_W-1:STRB_W] : req_strb[STRB_W-1:0];
        end
    end

    assign m_axi_wstrb = r_strb;
`else
    assign m_axi_wstrb = {STRB_W{1'b1}};
`endif

    assign req_done      = r_done;
    assign rsp_data      = r_rsp_data;
    assign rsp_resp      = r_rsp_resp;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_araddr  = r_addr;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_awprot  = AXI_PROT_DEFAULT;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_axil_gp_master_arb.sv
//----------------------------------------------------------------------------
// Module   : tb_axil_gp_master_arb
// Brief    : Self-checking bench with a reactive AXI4-Lite slave and a
//            completion scoreboard for axil_gp_master_arb.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_axil_gp_master_arb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_we = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
`ifdef AXIL_GP_STRB_EN
    logic [2*(DW/8)-1:0] req_strb = '1;
`endif
    logic [1:0]    req_done;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]    m_axi_awprot, m_axi_arprot;
    logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic          m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0;
    logic          m_axi_arready = 0, m_axi_rvalid = 0;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata = '0;
    logic [DW/8-1:0] m_axi_wstrb;
    logic [1:0]    m_axi_bresp = '0, m_axi_rresp = '0;

    axil_gp_master_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef AXIL_GP_STRB_EN
        .req_strb(req_strb),
`endif
        .req_done(req_done), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    done;
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   done_cyc = 0;

    // Slave configuration and observations
    int            aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]    bresp_val = 2'b00;
    logic [DW-1:0] rdata_val = '0;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int            aw_hs_cyc, w_hs_cyc, b_rise_cyc, ar_eps;
    logic          b_rose, ar_prev, aw_after;
    logic [AW-1:0] aw_seen, ar_seen;
    logic [DW-1:0] w_seen;
    logic [DW/8-1:0] strb_seen;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reactive AXI4-Lite slave, evaluated on the falling edge
    initial begin
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_hs_cyc = 0; w_hs_cyc = 0; b_rise_cyc = 0; ar_eps = 0;
        b_rose = 0; ar_prev = 0; aw_after = 0;
        aw_seen = '0; ar_seen = '0; w_seen = '0; strb_seen = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                b_rose = 0; ar_prev = 0;
            end else begin
                if (m_axi_awready) begin
                    m_axi_awready = 0; aw_after = m_axi_awvalid; aw_cnt = 0;
                end else if (m_axi_awvalid) begin
                    if (aw_cnt >= aw_wait) begin
                        m_axi_awready = 1; aw_hs_cyc = cyc; aw_seen = m_axi_awaddr;
                    end else aw_cnt++;
                end
                if (m_axi_wready) begin
                    m_axi_wready = 0; w_cnt = 0;
                end else if (m_axi_wvalid) begin
                    if (w_cnt >= w_wait) begin
                        m_axi_wready = 1; w_hs_cyc = cyc; w_seen = m_axi_wdata; strb_seen = m_axi_wstrb;
                    end else w_cnt++;
                end
                if (m_axi_bvalid) m_axi_bvalid = 0;
                else if (m_axi_bready) begin
                    if (!b_rose) begin b_rise_cyc = cyc; b_rose = 1; end
                    if (b_cnt >= b_wait) begin
                        m_axi_bvalid = 1; m_axi_bresp = bresp_val; b_cnt = 0; b_rose = 0;
                    end else b_cnt++;
                end
                if (m_axi_arvalid && !ar_prev) ar_eps++;
                ar_prev = m_axi_arvalid;
                if (m_axi_arready) begin
                    m_axi_arready = 0; ar_cnt = 0;
                end else if (m_axi_arvalid) begin
                    if (ar_cnt >= ar_wait) begin
                        m_axi_arready = 1; ar_seen = m_axi_araddr;
                    end else ar_cnt++;
                end
                if (m_axi_rvalid) m_axi_rvalid = 0;
                else if (m_axi_rready) begin
                    if (r_cnt >= r_wait) begin
                        m_axi_rvalid = 1; m_axi_rdata = rdata_val; m_axi_rresp = 2'b00; r_cnt = 0;
                    end else r_cnt++;
                end
            end
        end
    end

    // Completion monitor: every done must match the head of the scoreboard
    initial forever begin
        @(negedge clk);
        if (rst && req_done != 2'b00) begin
            done_cyc = cyc;
            if (sb.size() == 0) check_eq("unexpected_done", {62'd0, req_done}, 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("done_sel", {62'd0, req_done}, {62'd0, e.done});
                check_eq("rsp_resp", {62'd0, rsp_resp}, {62'd0, e.resp});
                check_eq("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
            end
        end
    end

    task automatic do_req(input int idx, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [1:0] eresp,
                          input logic [DW-1:0] edata, output int t0);
        exp_t e;
        logic got;
        e.done = (idx == 0) ? 2'b01 : 2'b10;
        e.resp = eresp;
        e.data = edata;
        sb.push_back(e);
        @(negedge clk);
        req_we[idx] = we;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*DW +: DW] = wd;
        req_valid[idx] = 1'b1;
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_done[idx]) got = 1'b1;
        end
        req_valid[idx] = 1'b0;
        check_eq("req_timeout", {63'd0, got}, 64'd1);
    endtask

    initial begin
        int t0;
        int cnt;
        logic seen;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
        check_eq("rst_wvalid",  {63'd0, m_axi_wvalid}, 64'd0);
        check_eq("rst_bready",  {63'd0, m_axi_bready}, 64'd0);
        check_eq("rst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        check_eq("rst_rready",  {63'd0, m_axi_rready}, 64'd0);
        check_eq("rst_done",    {62'd0, req_done}, 64'd0);
        check_eq("rst_rsp",     {30'd0, rsp_resp, rsp_data}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait write from requester 0
        do_req(0, 1'b1, 5'h04, 32'hDEADBEEF, 2'b00, 32'h0, t0);
        check_eq("wr_awaddr", {59'd0, aw_seen}, 64'h04);
        check_eq("wr_wdata",  {32'd0, w_seen}, 64'hDEADBEEF);
        check_eq("wr_wstrb",  {60'd0, strb_seen}, 64'hF);
        check_eq("wr_aw_cyc", aw_hs_cyc, t0 + 1);
        check_eq("wr_w_cyc",  w_hs_cyc, t0 + 1);
        check_eq("wr_latency", done_cyc - t0, 3);
        check_eq("awprot",    {61'd0, m_axi_awprot}, 64'd0);

        // Read from requester 1 with wait states
        ar_wait = 2; r_wait = 2; rdata_val = 32'h0000_00A5;
        ar_eps = 0;
        do_req(1, 1'b0, 5'h10, 32'h0, 2'b00, 32'h0000_00A5, t0);
        check_eq("rd_araddr", {59'd0, ar_seen}, 64'h10);
        check_eq("rd_ar_episodes", ar_eps, 1);
        ar_wait = 0; r_wait = 0;

        // AW/W skew
        w_wait = 3;
        do_req(0, 1'b1, 5'h08, 32'h1234_5678, 2'b00, 32'h0, t0);
        check_eq("skew_aw_cyc", aw_hs_cyc, t0 + 1);
        check_eq("skew_aw_drop", {63'd0, aw_after}, 64'd0);
        check_eq("skew_w_cyc",  w_hs_cyc, t0 + 4);
        check_eq("skew_bready_cyc", b_rise_cyc, t0 + 5);
        check_eq("skew_latency", done_cyc - t0, 6);
        w_wait = 0;

        // Slave error then normal read
        bresp_val = 2'b10;
        do_req(1, 1'b1, 5'h0C, 32'hCAFE_F00D, 2'b10, 32'h0, t0);
        bresp_val = 2'b00;
        rdata_val = 32'h5A5A_0001;
        do_req(0, 1'b0, 5'h14, 32'h0, 2'b00, 32'h5A5A_0001, t0);

        // Contention after fresh reset: strict alternation starting at 0
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.done = (k % 2 == 0) ? 2'b01 : 2'b10;
            e.resp = 2'b00;
            e.data = 32'h0;
            sb.push_back(e);
        end
        @(negedge clk);
        req_we = 2'b11;
        req_addr = {5'h1C, 5'h18};
        req_wdata = {32'h1111_1111, 32'h0000_0000};
        req_valid = 2'b11;
        cnt = 0;
        for (int i = 0; i < 400 && cnt < 4; i++) begin
            @(negedge clk);
            if (req_done != 2'b00) cnt++;
        end
        req_valid = 2'b00;
        check_eq("contention_count", cnt, 4);
        check_eq("contention_sb_empty", sb.size(), 0);

        // Reset in the middle of a write
        aw_wait = 20; w_wait = 20;
        @(negedge clk);
        req_we = 2'b01; req_addr = {5'h00, 5'h02};
        req_valid = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (m_axi_awvalid) seen = 1'b1;
        end
        check_eq("midrst_awvalid_seen", {63'd0, seen}, 64'd1);
        rst = 1'b0;
        #1;
        check_eq("midrst_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
        check_eq("midrst_wvalid",  {63'd0, m_axi_wvalid}, 64'd0);
        check_eq("midrst_bready",  {63'd0, m_axi_bready}, 64'd0);
        check_eq("midrst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        check_eq("midrst_done",    {62'd0, req_done}, 64'd0);
        req_valid = 2'b00;
        aw_wait = 0; w_wait = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // First grant after release must go to requester 0
        begin
            exp_t e;
            e.done = 2'b01; e.resp = 2'b00; e.data = 32'h0;
            sb.push_back(e);
        end
        @(negedge clk);
        req_we = 2'b11;
        req_valid = 2'b11;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (req_done != 2'b00) seen = 1'b1;
        end
        req_valid = 2'b00;
        check_eq("post_rst_done_seen", {63'd0, seen}, 64'd1);
        repeat (10) @(negedge clk);
        check_eq("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
